// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding, line-mode codes and phase lengths shared by the SPI target.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA} state_t;
  localparam logic [1:0] SINGLE = 2'b00, DUAL = 2'b01, QUAD = 2'b10;
  localparam int CMD_BITS = 8, ADDR_BITS = 24, DATA_BITS = 32;
  function automatic logic [2:0] lane_width(input logic [1:0] mode);
    return mode == SINGLE ? 3'd1 : mode == DUAL ? 3'd2 : mode == QUAD ? 3'd4 : 3'd1;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with one-clk rise/fall pulses on the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign rise = sync[STAGES-1] & ~prev;
  assign fall = ~sync[STAGES-1] & prev;
endmodule

// File: rtl/spi_target_resp.sv
// spi_target_resp: mode-0 SPI target with single/dual/quad command, address, read and write phases.
module spi_target_resp import spi_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ss_n,
  input  logic [3:0]  data_rx,
  output logic [3:0]  data_tx,
  output logic [3:0]  data_oe,
  input  logic [1:0]  addr_mode,
  input  logic [1:0]  data_mode,
  input  logic [3:0]  dummy_cycles,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [23:0] addr,
  input  logic [31:0] rd_data,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  output logic        busy
);
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES*4-1:0] rx_dly;
  logic [3:0] rx, tx_grp, oe_nx, dummy_left;
  logic [2:0] aw, dw;
  logic [5:0] cnt, acnt_nx, dcnt_nx;
  logic [7:0] cmd_sr;
  logic [23:0] addr_sr, addr_nx;
  logic [31:0] tx_sr, tx_sh, rx_sr, rx_nx;
  state_t state;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (.clk(clk), .rst(rst), .d(ss_n), .rise(ss_rise), .fall(ss_fall));

  // data lines get the same delay as sclk so the detected rise samples the bits present at the real edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) rx_dly <= '0;
    else rx_dly <= {rx_dly[SYNC_STAGES*4-5:0], data_rx};
  assign rx = rx_dly[SYNC_STAGES*4-1 -: 4];

  always_comb begin
    aw = lane_width(addr_mode);
    dw = lane_width(data_mode);
    acnt_nx = cnt + 6'(aw);
    dcnt_nx = cnt + 6'(dw);
    addr_nx = aw == 3'd4 ? {addr_sr[19:0], rx} : aw == 3'd2 ? {addr_sr[21:0], rx[1:0]} : {addr_sr[22:0], rx[0]};
    rx_nx = dw == 3'd4 ? {rx_sr[27:0], rx} : dw == 3'd2 ? {rx_sr[29:0], rx[1:0]} : {rx_sr[30:0], rx[0]};
    tx_grp = dw == 3'd4 ? tx_sr[31:28] : dw == 3'd2 ? {2'b00, tx_sr[31:30]} : {2'b00, tx_sr[31], 1'b0};
    tx_sh = dw == 3'd4 ? {tx_sr[27:0], 4'h0} : dw == 3'd2 ? {tx_sr[29:0], 2'b00} : {tx_sr[30:0], 1'b0};
    oe_nx = dw == 3'd4 ? 4'b1111 : dw == 3'd2 ? 4'b0011 : 4'b0010;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      dummy_left <= '0;
      cmd_sr <= '0;
      addr_sr <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      cmd <= '0;
      addr <= '0;
      wr_data <= '0;
      data_tx <= '0;
      data_oe <= '0;
      cmd_valid <= 1'b0;
      wr_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      wr_valid <= 1'b0;
      if (ss_fall) busy <= 1'b1;
      if (ss_rise) begin
        busy <= 1'b0;
        state <= IDLE;
        cnt <= '0;
        data_oe <= '0;
        data_tx <= '0;
      end else
        case (state)
          IDLE: if (ss_fall) begin
            state <= CMD;
            cnt <= '0;
          end
          CMD: if (sclk_rise) begin
            cmd_sr <= {cmd_sr[6:0], rx[0]};
            cnt <= cnt == 6'(CMD_BITS - 1) ? '0 : cnt + 6'd1;
            if (cnt == 6'(CMD_BITS - 1)) state <= ADDR;
          end
          ADDR: if (cmd_valid) begin
            cnt <= '0;
            dummy_left <= dummy_cycles;
            if (cmd[7]) tx_sr <= rd_data;
            if (cmd[7] && dummy_cycles == 4'd0) data_oe <= oe_nx;
            state <= !cmd[7] ? WDATA : dummy_cycles != 4'd0 ? DUMMY : RDATA;
          end else if (sclk_rise) begin
            addr_sr <= addr_nx;
            cnt <= acnt_nx;
            if (acnt_nx == 6'(ADDR_BITS)) begin
              cmd <= cmd_sr;
              addr <= addr_nx;
              cmd_valid <= 1'b1;
            end
          end
          DUMMY: if (sclk_rise) begin
            dummy_left <= dummy_left - 4'd1;
            if (dummy_left == 4'd1) begin
              state <= RDATA;
              data_oe <= oe_nx;
            end
          end
          // zeros shift in behind the word, so the lines fall to 0 once all 32 bits are out
          RDATA: if (sclk_fall) begin
            data_tx <= tx_grp;
            tx_sr <= tx_sh;
          end
          WDATA: if (sclk_rise) begin
            rx_sr <= rx_nx;
            cnt <= dcnt_nx == 6'(DATA_BITS) ? '0 : dcnt_nx;
            if (dcnt_nx == 6'(DATA_BITS)) begin
              wr_data <= rx_nx;
              wr_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_target_resp.sv
// tb_spi_target_resp: randomized and directed transactions checked by a queue scoreboard.
module tb_spi_target_resp;
  localparam int SYNC = 2;
  logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, ss_n = 1'b1;
  logic [3:0] data_rx = '0, dummy_cycles = '0;
  logic [1:0] addr_mode = '0, data_mode = '0;
  logic [31:0] rd_data = '0;
  logic [3:0] data_tx, data_oe;
  logic [7:0] cmd;
  logic [23:0] addr;
  logic [31:0] wr_data;
  logic cmd_valid, wr_valid, busy;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_cmd_q[$], exp_wr_q[$], wq[$];

  spi_target_resp #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .data_rx(data_rx), .data_tx(data_tx),
    .data_oe(data_oe), .addr_mode(addr_mode), .data_mode(data_mode), .dummy_cycles(dummy_cycles),
    .cmd(cmd), .cmd_valid(cmd_valid), .addr(addr), .rd_data(rd_data), .wr_data(wr_data),
    .wr_valid(wr_valid), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, expected no pulse", name, act);
  endtask

  // monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (cmd_valid) begin
      if (exp_cmd_q.size() == 0) unexpected("cmd_valid", {cmd, addr});
      else check("cmd/addr", {cmd, addr}, exp_cmd_q.pop_front());
    end
    if (wr_valid) begin
      if (exp_wr_q.size() == 0) unexpected("wr_valid", wr_data);
      else check("wr_data", wr_data, exp_wr_q.pop_front());
    end
  end

  // one sclk period; the target's reply is taken late in the high phase, as a delayed-sampling host does
  task automatic sck(input logic [3:0] rx, input int half, output logic [3:0] tx);
    data_rx = rx;
    #(half * 10);
    sclk = 1'b1;
    #(half * 10);
    tx = data_tx;
    sclk = 1'b0;
  endtask

  function automatic int width(input logic [1:0] m);
    return m == 2'b01 ? 2 : m == 2'b10 ? 4 : 1;
  endfunction

  task automatic txn(input logic [7:0] c, input logic [23:0] a, input logic [1:0] am, input logic [1:0] dm,
                     input logic [3:0] dc, input logic [31:0] rd, input int nw, input int abort_ab,
                     input int rst_at, input int half);
    int aw, dw, na;
    logic [3:0] tx, oe_exp, tail;
    logic [31:0] got, w;
    logic oe_ok;
    aw = width(am);
    dw = width(dm);
    na = abort_ab >= 0 ? abort_ab / aw : 24 / aw;
    oe_exp = dw == 4 ? 4'b1111 : dw == 2 ? 4'b0011 : 4'b0010;
    addr_mode = am;
    data_mode = dm;
    dummy_cycles = dc;
    rd_data = rd;
    @(posedge clk);
    #($urandom_range(1, 9));
    if (abort_ab < 0) exp_cmd_q.push_back({c, a});
    ss_n = 1'b0;
    #60;
    for (int i = 0; i < 8; i++) sck({3'b000, c[7-i]}, half, tx);
    for (int i = 0; i < na; i++) sck(4'((a >> (24 - (i + 1) * aw)) & ((1 << aw) - 1)), half, tx);
    if (abort_ab >= 0) begin
      #20 ss_n = 1'b1;
      repeat (SYNC + 2) @(posedge clk);
      #1;
      check("abort data_oe", data_oe, 0);
      check("abort busy", busy, 0);
      check("abort state", 64'(dut.state), 64'(spi_pkg::IDLE));
      #100;
      return;
    end
    if (c[7]) begin
      for (int i = 0; i < dc; i++) sck(4'h0, half, tx);
      got = '0;
      oe_ok = 1'b1;
      for (int i = 0; i < 32 / dw; i++) begin
        if (i == rst_at) begin
          #7 rst = 1'b0;
          #2;
          check("reset data_oe", data_oe, 0);
          check("reset data_tx", data_tx, 0);
          check("reset cmd/addr", {cmd, addr}, 0);
          check("reset busy/pulses", {busy, cmd_valid, wr_valid}, 0);
          ss_n = 1'b1;
          #40 rst = 1'b1;
          #100;
          return;
        end
        sck(4'h0, half, tx);
        got = (got << dw) | 32'(dw == 4 ? tx : dw == 2 ? {2'b00, tx[1:0]} : {3'b000, tx[1]});
        if (data_oe !== oe_exp) oe_ok = 1'b0;
      end
      check("read word", got, rd);
      check("read data_oe", {oe_ok, data_oe}, {1'b1, oe_exp});
      sck(4'h0, half, tail);
      sck(4'h0, half, tx);
      check("read tail zero", (tail | tx) & oe_exp, 0);
    end else
      for (int k = 0; k < nw; k++) begin
        w = wq.size() != 0 ? wq.pop_front() : $urandom;
        exp_wr_q.push_back(w);
        for (int i = 0; i < 32 / dw; i++) sck(4'((w >> (32 - (i + 1) * dw)) & ((1 << dw) - 1)), half, tx);
      end
    #20 ss_n = 1'b1;
    data_rx = '0;
    #100;
    check("idle data_oe", {busy, data_oe}, 0);
  endtask

  logic [7:0] rc;
  logic [23:0] ra;
  logic [1:0] ram, rdm;
  logic [3:0] rdc;
  int rnw, rab;

  initial begin
    #12;
    check("reset cmd/addr", {cmd, addr}, 0);
    check("reset wr_data", wr_data, 0);
    check("reset tx/oe", {data_tx, data_oe}, 0);
    check("reset pulses/busy", {cmd_valid, wr_valid, busy}, 0);
    rst = 1'b1;
    #50;
    txn(8'h8B, 24'h123456, 2'b00, 2'b00, 4'd0, 32'hDEADBEEF, 0, -1, -1, 2);
    txn(8'hEB, 24'h89ABCD, 2'b10, 2'b10, 4'd8, 32'hA5A55A5A, 0, -1, -1, 2);
    wq.push_back(32'h01234567);
    wq.push_back(32'h89ABCDEF);
    txn(8'h02, 24'h000100, 2'b00, 2'b01, 4'd0, 32'h0, 2, -1, -1, 2);
    txn(8'h03, 24'hABCDEF, 2'b00, 2'b00, 4'd0, 32'h0, 0, 12, -1, 2);
    txn(8'h8B, 24'h111111, 2'b00, 2'b00, 4'd0, 32'hCAFEF00D, 0, -1, 10, 2);
    txn(8'h9C, 24'h0F0F0F, 2'b01, 2'b01, 4'd3, 32'h13579BDF, 0, -1, -1, 3);
    for (int t = 0; t < 100; t++) begin
      rc = 8'($urandom);
      ra = 24'($urandom);
      ram = 2'($urandom);
      rdm = 2'($urandom);
      rdc = 4'($urandom);
      rnw = $urandom_range(1, 2);
      rab = $urandom_range(0, 9) == 0 ? $urandom_range(0, 24 / width(ram) - 1) * width(ram) : -1;
      txn(rc, ra, ram, rdm, rdc, 32'($urandom), rnw, rab, -1, 2);
    end
    repeat (20) @(posedge clk);
    check("cmd queue drained", exp_cmd_q.size(), 0);
    check("wr queue drained", exp_wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_target_resp.md
SPI_TARGET_RESP -- requirements
Module: spi_target_resp

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the depth of the synchronizer on the sclk and ss_n inputs (minimum 2).
REQ-002 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports:
- sclk  in  1  SPI serial clock; asynchronous; mode 0.
- ss_n  in  1  target select, active-low; asynchronous.
- data_rx  in  4  SPI lines from the initiator: [0]=MOSI/IO0 … [3]=IO3.
- data_tx  out  4  SPI lines to the initiator; in single mode MISO is [1].
- data_oe  out  4  per-line output enable.
- addr_mode  in  2  address-phase line width: 00 single, 01 dual, 10 quad, 11 single.
- data_mode  in  2  data-phase line width, same encoding.
- dummy_cycles  in  4  sclk cycles between the address phase and a read-data phase.
- cmd  out  8  captured opcode; cmd_valid  out  1  one-clk pulse after the address is complete.
- addr  out  24  captured address.
- rd_data  in  32  word to send; latched on the cmd_valid cycle.
- wr_data  out  32  received word; wr_valid  out  1  one-clk pulse per received word.
- busy  out  1  high while ss_n is asserted (synchronized).

Function
REQ-005 SHALL pass sclk and ss_n through SYNC_STAGES flops, then detect rising and falling sclk edges from the synchronized values; the required maximum sclk frequency is clk/4.
REQ-006 SHALL sample data_rx on the detected sclk rising edge and update data_tx on the detected falling edge (mode 0).
REQ-007 FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA.
REQ-008 IDLE->CMD on the synchronized ss_n falling edge; the bit counter clears to 0.
REQ-009 CMD SHALL shift 8 bits MSB-first from data_rx[0]; after the 8th bit -> ADDR.
REQ-010 ADDR SHALL shift 24 bits MSB-first at the width set by addr_mode: single 1 bit/edge from [0], dual 2 bits/edge from [1:0], quad 4 bits/edge from [3:0]; after 24 bits: cmd/addr update and cmd_valid pulses the next clk.
REQ-011 On the cmd_valid cycle, if cmd[7]=1 SHALL latch rd_data into the tx shift register and go to DUMMY when dummy_cycles≠0, otherwise to RDATA; if cmd[7]=0 SHALL go to WDATA.
REQ-012 DUMMY SHALL count dummy_cycles rising edges, then go to RDATA.
REQ-013 On entry to RDATA, data_oe SHALL be 0010 (single), 0011 (dual) or 1111 (quad); the first MSB group SHALL be driven on the falling edge after the last address or dummy rising edge, so it is valid at the first RDATA rising edge.
REQ-014 After 32 bits, RDATA SHALL drive 0 on the enabled lines until ss_n deasserts.
REQ-015 WDATA SHALL shift 32 bits MSB-first at data_mode width; wr_data updates and wr_valid pulses once per complete word; the counter wraps for continuous words.
REQ-016 ss_n deassertion in any state SHALL go to IDLE the next clk: data_oe=0, partial words discarded, no cmd_valid or wr_valid pulse.
REQ-017 Bit counters SHALL be 6 bits; modes 11 are treated as single; dummy_cycles is sampled on the cmd_valid cycle.
REQ-018 data_tx SHALL be 0 whenever data_oe=0.

Reset
REQ-019 While rst=0: state=IDLE; cmd, addr, wr_data, data_tx, data_oe = 0; cmd_valid, wr_valid, busy = 0; synchronizers preset to sclk=0, ss_n=1.
REQ-020 Reset assertion mid-transfer SHALL abort immediately; after release, the block SHALL wait for a fresh ss_n falling edge.

Structure
REQ-021 A shared package spi_pkg SHALL hold the FSM state encoding, line-mode codes (SINGLE/DUAL/QUAD) and the phase lengths (CMD_BITS=8, ADDR_BITS=24, DATA_BITS=32).
REQ-022 One sub-module, spi_sync_edge, SHALL contain the synchronizer and rise/fall pulse generation; it is instantiated for sclk and ss_n.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single read: cmd 0x8B, addr 0x123456, dummy 0, rd_data 0xDEADBEEF -> cmd_valid once; data_tx[1] carries 0xDEADBEEF MSB-first; data_oe=0010.
- Quad read: addr_mode=10, data_mode=10, dummy 8, rd_data 0xA5A55A5A -> addr in 6 sclk; nibbles A,5,A,5,5,A,5,A on the 9th to 16th post-address rising edges.
- Dual write: cmd 0x02, data_mode=01, two words 0x01234567, 0x89ABCDEF -> two wr_valid pulses, wr_data in order.
- Abort: ss_n rises after 12 address bits -> no cmd_valid, state IDLE, data_oe=0 within SYNC_STAGES+2 clk.
- Reset: rst low during RDATA -> all outputs 0 asynchronously; the next full transaction completes correctly.
- Max rate: sclk=clk/4 with random clk phase -> no lost or duplicated bits over 100 transactions.
